// File: rtl/lcd_field_writer.sv
// Writes one fixed-length text field to a 20x4 HD44780 LCD: a DDRAM address
// command followed by FIELD_LEN filtered characters, each with a three-phase E strobe.
module lcd_field_writer #(
   parameter int unsigned TICK_CYCLES = 50000,
   parameter int unsigned FIELD_LEN   = 8,
   parameter int unsigned COL_OFFSET  = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [1:0]             line_sel,
   input  logic [8*FIELD_LEN-1:0] data,
   output logic                   busy,
   output logic                   done,
   output logic                   RS,
   output logic                   E,
   output logic [7:0]             DB
);

   localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int unsigned IW = (FIELD_LEN > 1) ? $clog2(FIELD_LEN) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(FIELD_LEN - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_CHAR = 2'd2;

   localparam logic [1:0] PH_SETUP = 2'd0;
   localparam logic [1:0] PH_PULSE = 2'd1;
   localparam logic [1:0] PH_HOLD  = 2'd2;

   logic [1:0]    state;
   logic [1:0]    phase;
   logic [TW-1:0] tick;
   logic [IW-1:0] idx;
   logic [7:0]    chars_q [FIELD_LEN];
   logic [7:0]    line_base;
   logic [7:0]    addr_byte;

   // Non-printable characters are shown as blanks.
   function automatic logic [7:0] printable(input logic [7:0] c);
      return (c < 8'h20 || c > 8'h7E) ? 8'h20 : c;
   endfunction

   always_comb begin
      line_base = 8'hC0;
      unique case (line_sel)
         2'd0: line_base = 8'hC0;
         2'd1: line_base = 8'h80;
         2'd2: line_base = 8'h94;
         2'd3: line_base = 8'hD4;
      endcase
      addr_byte = line_base + 8'(COL_OFFSET);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         phase <= PH_SETUP;
         tick  <= '0;
         idx   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         RS    <= 1'b0;
         E     <= 1'b0;
         DB    <= '0;
      end else begin
         done <= 1'b0;
         if (state == ST_IDLE) begin
            if (start) begin
               state <= ST_ADDR;
               phase <= PH_SETUP;
               tick  <= '0;
               idx   <= '0;
               busy  <= 1'b1;
               RS    <= 1'b0;
               E     <= 1'b0;
               DB    <= addr_byte;
               for (int unsigned i = 0; i < FIELD_LEN; i++)
                  chars_q[i] <= printable(data[8*i +: 8]);
            end
         end else if (tick != TICK_LAST) begin
            tick <= tick + TW'(1);
         end else begin
            tick <= '0;
            unique case (phase)
               PH_SETUP: begin
                  phase <= PH_PULSE;
                  E     <= 1'b1;
               end
               PH_PULSE: begin
                  phase <= PH_HOLD;
                  E     <= 1'b0;
               end
               default: begin
                  // End of HOLD: RS/DB change only here, so E never rises with them.
                  phase <= PH_SETUP;
                  if (state == ST_ADDR) begin
                     state <= ST_CHAR;
                     idx   <= '0;
                     RS    <= 1'b1;
                     DB    <= chars_q[0];
                  end else if (idx != IDX_LAST) begin
                     idx <= idx + IW'(1);
                     DB  <= chars_q[idx + IW'(1)];
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lcd_field_writer.sv
// Bench for lcd_field_writer: table-driven fields, hand-written corner sequences,
// and a randomized run checked cycle-by-cycle against a transaction-level model.
module tb_lcd_field_writer;

   localparam int T   = 4;
   localparam int L   = 4;
   localparam int OFF = 5;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [1:0]     line_sel = '0;
   logic [8*L-1:0] data = '0;
   logic           busy, done, RS, E;
   logic [7:0]     DB;

   lcd_field_writer #(.TICK_CYCLES(T), .FIELD_LEN(L), .COL_OFFSET(OFF)) dut (
      .clk(clk), .rst(rst), .start(start), .line_sel(line_sel), .data(data),
      .busy(busy), .done(done), .RS(RS), .E(E), .DB(DB)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       rs;
      logic       e;
      logic [7:0] db;
   } out_t;

   typedef struct {
      logic [1:0]     ls;
      logic [8*L-1:0] d;
      logic [39:0]    exp_bytes;   // byte k in [8k+7:8k], byte 0 = address
   } vec_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   out_t exp_q[$];
   out_t cur = '0;
   bit   model_on = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] base_of(input logic [1:0] l);
      case (l)
         2'd0: return 8'hC0;
         2'd1: return 8'h80;
         2'd2: return 8'h94;
         default: return 8'hD4;
      endcase
   endfunction

   function automatic logic [7:0] shown(input logic [7:0] c);
      return (c < 8'h20 || c > 8'h7E) ? 8'h20 : c;
   endfunction

   // Reference: on acceptance, expand the field into its full per-cycle output trace.
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         cur = '0;
         model_on = 1;
      end else if (model_on) begin
         if (!cur.busy && start) begin
            logic [7:0] bytes [L+1];
            bytes[0] = base_of(line_sel) + 8'(OFF);
            for (int k = 0; k < L; k++) bytes[k+1] = shown(data[8*k +: 8]);
            for (int b = 0; b <= L; b++)
               for (int p = 0; p < 3; p++)
                  for (int t = 0; t < T; t++)
                     exp_q.push_back('{busy: 1'b1, done: 1'b0, rs: (b > 0), e: (p == 1), db: bytes[b]});
            exp_q.push_back('{busy: 1'b0, done: 1'b1, rs: 1'b1, e: 1'b0, db: bytes[L]});
         end
         if (exp_q.size() > 0) cur = exp_q.pop_front();
         else begin
            cur.busy = 1'b0;
            cur.done = 1'b0;
            cur.e    = 1'b0;
         end
      end
   end

   always @(negedge clk)
      if (model_on && !rst) check("cycle", 32'({busy, done, RS, E, DB}), 32'(cur));

   task automatic wait_idle();
      int n = 0;
      while (busy === 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 32'(busy), 32'(0));
   endtask

   task automatic run_field(input vec_t v, input int repulse, input string tag);
      logic [8:0] got[$];
      int   busy_cnt = 0;
      int   done_at  = 0;
      logic prev_e   = 1'b0;
      wait_idle();
      line_sel = v.ls;
      data     = v.d;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      data     = $urandom;
      line_sel = 2'($urandom);
      for (int n = 1; n <= 200; n++) begin
         if (busy) busy_cnt++;
         if (E && !prev_e) got.push_back({RS, DB});
         prev_e = E;
         if (done) begin
            done_at = n;
            break;
         end
         start = (n == repulse);
         if (n == repulse) begin
            line_sel = 2'd2;
            data     = $urandom;
         end
         @(negedge clk);
      end
      check({tag, "_nbytes"}, 32'(got.size()), 32'(L + 1));
      for (int k = 0; k <= L && k < got.size(); k++)
         check($sformatf("%s_byte%0d", tag, k), 32'(got[k]), 32'({(k > 0), v.exp_bytes[8*k +: 8]}));
      check({tag, "_busy_len"}, 32'(busy_cnt), 32'(3 * (L + 1) * T));
      check({tag, "_done_at"}, 32'(done_at), 32'(3 * (L + 1) * T + 1));
   endtask

   initial begin
      vec_t vecs [5];
      int   seen;
      int   dones;
      int   first_done;
      vecs[0] = '{ls: 2'd1, d: 32'h5A314241, exp_bytes: 40'h5A31424185};
      vecs[1] = '{ls: 2'd0, d: 32'h5A314241, exp_bytes: 40'h5A314241C5};
      vecs[2] = '{ls: 2'd2, d: 32'h5A314241, exp_bytes: 40'h5A31424199};
      vecs[3] = '{ls: 2'd3, d: 32'h5A314241, exp_bytes: 40'h5A314241D9};
      vecs[4] = '{ls: 2'd1, d: 32'h20417F01, exp_bytes: 40'h2041202085};

      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({busy, done, RS, E, DB}), 32'(0));
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_field(vecs[i], -1, $sformatf("vec%0d", i));

      run_field(vecs[0], 10, "ignore_start");

      // Reset in the middle of the first character's strobe.
      wait_idle();
      line_sel = 2'd1;
      data     = vecs[0].d;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_E", 32'(E), 32'(0));
      check("rst_mid_busy", 32'(busy), 32'(0));
      check("rst_mid_DB", 32'(DB), 32'(0));
      check("rst_mid_RS", 32'(RS), 32'(0));
      rst  = 1'b0;
      seen = 0;
      repeat (70) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("rst_no_done", 32'(seen), 32'(0));
      run_field(vecs[0], -1, "after_rst");

      // start held high: back-to-back fields.
      wait_idle();
      line_sel   = 2'd3;
      data       = vecs[0].d;
      start      = 1'b1;
      dones      = 0;
      first_done = 0;
      for (int n = 1; n <= 130; n++) begin
         @(negedge clk);
         if (done) begin
            dones++;
            if (first_done == 0) first_done = n;
         end
         if (first_done != 0 && n == first_done + 1)
            check("b2b_second_addr", 32'({busy, RS, DB}), 32'({1'b1, 1'b0, 8'hD9}));
         if (n == 122) check("b2b_second_done", 32'(done), 32'(1));
      end
      start = 1'b0;
      check("b2b_first_done_at", 32'(first_done), 32'(61));
      check("b2b_done_count", 32'(dones), 32'(2));
      wait_idle();

      for (int c = 0; c < 3000; c++) begin
         rst      = ($urandom_range(0, 299) == 0);
         start    = ($urandom_range(0, 7) == 0);
         line_sel = 2'($urandom);
         data     = $urandom;
         @(negedge clk);
      end
      rst   = 1'b0;
      start = 1'b0;
      repeat (70) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
